// File: rtl/fft_bfly_sched.sv
// fft_bfly_sched: in-place radix-2 FFT butterfly scheduler.
// Walks LOG2_N stages of N/2 butterflies, issuing operand reads, a two-cycle
// butterfly enable pair and two in-place writes per butterfly. A two-cycle
// DRAIN between stages lets the last writes land before the next stage reads.
// Optional feature macro: FFT_SCHED_ABORT_EN (adds i_abort, graceful stop).
module fft_bfly_sched #(
   parameter int DATA_FFT_SIZE = 16,
   parameter int LOG2_N        = 4,
   localparam int TW_W         = (LOG2_N > 1) ? LOG2_N - 1 : 1,
   localparam int STG_W        = $clog2(LOG2_N) + 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
`ifdef FFT_SCHED_ABORT_EN
   input  logic              i_abort,
`endif
   output logic              o_busy,
   output logic              o_done,
   output logic              o_rd_en,
   output logic [LOG2_N-1:0] o_rd_addr0,
   output logic [LOG2_N-1:0] o_rd_addr1,
   output logic              o_bfly_en,
   output logic              o_wr_en,
   output logic [LOG2_N-1:0] o_wr_addr,
   output logic [TW_W-1:0]   o_tw_addr,
   output logic [STG_W-1:0]  o_stage
);

   // Sample width rides along for integration only; scaled by zero so it can
   // never influence the schedule.
   localparam int                N          = (1 << LOG2_N) + 0 * DATA_FFT_SIZE;
   localparam logic [LOG2_N-1:0] ONE        = LOG2_N'(1);
   localparam logic [STG_W-1:0]  STG_ONE    = STG_W'(1);
   localparam logic [LOG2_N-1:0] LAST_BFLY  = LOG2_N'(N / 2 - 1);
   localparam logic [STG_W-1:0]  LAST_STAGE = STG_W'(LOG2_N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t              state, state_next;
   logic [STG_W-1:0]    stage;
   logic [LOG2_N-1:0]   bfly;
   logic                phase;      // 0: read cycle T, 1: hold cycle T+1
   logic                drain_cnt;
   logic                abort_q;
   logic                done_q;
   logic                rd_en, hold;
   logic                rd_q1, rd_q2, rd_q3;
   logic [LOG2_N-1:0]   a0_d1, a1_d1, a1_d2;
   logic [LOG2_N-1:0]   span, pos, addr0, addr1;
   logic                last_bfly, last_stage;

   assign last_bfly  = (bfly == LAST_BFLY);
   assign last_stage = (stage == LAST_STAGE);

   // Butterfly operand addresses: span is a power of two, so mod/div reduce to masks.
   always_comb begin
      span  = ONE << (LAST_STAGE - stage);
      pos   = bfly & (span - ONE);
      addr0 = ((bfly & ~(span - ONE)) << 1) | pos;
      addr1 = addr0 | span;
   end

   // Next-state decode and read-side strobes.
   // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_next = state;
      rd_en      = 1'b0;
      hold       = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) state_next = RUN;
         end
         RUN: begin
            rd_en = ~phase;
            hold  = 1'b1;
            if (phase && (last_bfly || abort_q)) state_next = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt) state_next = (last_stage || abort_q) ? IDLE : RUN;
         end
         default: state_next = IDLE;
      endcase
   end

   assign o_rd_en    = rd_en;
   assign o_rd_addr0 = hold ? addr0 : '0;
   assign o_rd_addr1 = hold ? addr1 : '0;
   assign o_tw_addr  = hold ? TW_W'(pos << stage) : '0;
   assign o_stage    = stage;
   assign o_busy     = (state != IDLE);
   assign o_bfly_en  = rd_q1 | rd_q2;
   assign o_wr_en    = rd_q2 | rd_q3;
   assign o_wr_addr  = rd_q2 ? a0_d1 : (rd_q3 ? a1_d2 : '0);
   assign o_done     = done_q;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_next;
   end

   // Stage/butterfly counters plus the read-to-butterfly-to-write pipeline.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stage     <= '0;
         bfly      <= '0;
         phase     <= 1'b0;
         drain_cnt <= 1'b0;
         done_q    <= 1'b0;
         rd_q1     <= 1'b0;
         rd_q2     <= 1'b0;
         rd_q3     <= 1'b0;
         a0_d1     <= '0;
         a1_d1     <= '0;
         a1_d2     <= '0;
      end else begin
         rd_q1     <= rd_en;
         rd_q2     <= rd_q1;
         rd_q3     <= rd_q2;
         a0_d1     <= o_rd_addr0;
         a1_d1     <= o_rd_addr1;
         a1_d2     <= a1_d1;
         done_q    <= (state == DRAIN) && drain_cnt && last_stage && !abort_q;
         drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
         case (state)
            IDLE: begin
               stage <= '0;
               bfly  <= '0;
               phase <= 1'b0;
            end
            RUN: begin
               phase <= ~phase;
               if (phase) bfly <= last_bfly ? '0 : bfly + ONE;
            end
            DRAIN: begin
               if (drain_cnt) stage <= (state_next == IDLE) ? '0 : stage + STG_ONE;
            end
            default: ;
         endcase
      end
   end

`ifdef FFT_SCHED_ABORT_EN
   // Latch an abort seen in RUN; it stops reads at the next butterfly boundary.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                      abort_q <= 1'b0;
      else if (state == IDLE)         abort_q <= 1'b0;
      else if (state == RUN && i_abort) abort_q <= 1'b1;
   end
`else
   assign abort_q = 1'b0;
`endif

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Self-checking bench for fft_bfly_sched (LOG2_N = 4). Expected per-cycle
// outputs come from a schedule model built from the butterfly/stage formulas.
module tb_fft_bfly_sched;
   localparam int LOG2_N = 4;
   localparam int N      = 16;
   localparam int LEN    = 80;

   logic       clk = 1'b0;
   logic       rst, start;
`ifdef FFT_SCHED_ABORT_EN
   logic       abort;
`endif
   logic       busy, done, rd_en, bfly_en, wr_en;
   logic [3:0] rd_addr0, rd_addr1, wr_addr;
   logic [2:0] tw_addr, stage;

   always #5 clk = ~clk;

   fft_bfly_sched #(.DATA_FFT_SIZE(16), .LOG2_N(LOG2_N)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
`ifdef FFT_SCHED_ABORT_EN
      .i_abort(abort),
`endif
      .o_busy(busy), .o_done(done), .o_rd_en(rd_en),
      .o_rd_addr0(rd_addr0), .o_rd_addr1(rd_addr1), .o_bfly_en(bfly_en),
      .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_tw_addr(tw_addr), .o_stage(stage)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input int cyc, input logic [31:0] act, input int exp);
      n_vec++;
      if (act !== 32'(exp)) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Expected schedule, indexed by cycle relative to the start cycle.
   bit e_rd[LEN], e_bf[LEN], e_wr[LEN], e_busy[LEN], e_done[LEN], e_hold[LEN];
   int e_a0[LEN], e_a1[LEN], e_tw[LEN], e_stg[LEN], e_wa[LEN];

   // Observations from the latest run.
   int obs_a0[64], obs_a1[64], obs_tw[64];
   int n_reads, n_bf, n_wr, n_busy, done_cyc;

   task automatic build_model(input int rst_at, input int abort_at);
      int last_wr;
      last_wr = 0;
      for (int k = 0; k < LEN; k++) begin
         e_rd[k] = 0; e_bf[k] = 0; e_wr[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_hold[k] = 0;
         e_a0[k] = 0; e_a1[k] = 0; e_tw[k] = 0; e_stg[k] = 0; e_wa[k] = 0;
      end
      for (int s = 0; s < LOG2_N; s++) begin
         for (int b = 0; b < N / 2; b++) begin
            int t, span, pos, grp, a0, a1;
            t    = 1 + s * (N + 2) + 2 * b;
            span = N >> (s + 1);
            pos  = b % span;
            grp  = b / span;
            a0   = 2 * span * grp + pos;
            a1   = a0 + span;
            if (abort_at < 0 || t <= abort_at + 1) begin
               e_rd[t] = 1;
               for (int h = 0; h < 2; h++) begin
                  e_hold[t+h] = 1; e_a0[t+h] = a0; e_a1[t+h] = a1;
                  e_tw[t+h] = pos << s; e_stg[t+h] = s;
               end
               e_bf[t+1] = 1; e_bf[t+2] = 1;
               e_wr[t+2] = 1; e_wa[t+2] = a0;
               e_wr[t+3] = 1; e_wa[t+3] = a1;
               if (t + 3 > last_wr) last_wr = t + 3;
            end
         end
      end
      for (int k = 1; k <= last_wr; k++) e_busy[k] = 1;
      if (abort_at < 0) e_done[last_wr+1] = 1;
      if (rst_at >= 0) begin
         for (int k = rst_at; k < LEN; k++) begin
            e_rd[k] = 0; e_bf[k] = 0; e_wr[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_hold[k] = 0;
            e_a0[k] = 0; e_a1[k] = 0; e_tw[k] = 0; e_stg[k] = 0; e_wa[k] = 0;
         end
         e_hold[rst_at] = 1;  // outputs must read zero in the reset cycle itself
      end
   endtask

   // Entered just after a rising edge; cycle 0 carries the start request.
   task automatic run_sched(input int noise_at, input int rst_at, input int abort_at);
      build_model(rst_at, abort_at);
      n_reads = 0; n_bf = 0; n_wr = 0; n_busy = 0; done_cyc = -1;
      for (int k = 0; k < LEN; k++) begin
         start = (k == 0) || (k == noise_at);
         rst   = (k == rst_at);
`ifdef FFT_SCHED_ABORT_EN
         abort = (k == abort_at);
`endif
         @(negedge clk);
         check("rd_en",   k, rd_en,   e_rd[k]);
         check("bfly_en", k, bfly_en, e_bf[k]);
         check("wr_en",   k, wr_en,   e_wr[k]);
         check("busy",    k, busy,    e_busy[k]);
         check("done",    k, done,    e_done[k]);
         if (e_wr[k]) check("wr_addr", k, wr_addr, e_wa[k]);
         if (e_hold[k]) begin
            check("rd_addr0", k, rd_addr0, e_a0[k]);
            check("rd_addr1", k, rd_addr1, e_a1[k]);
            check("tw_addr",  k, tw_addr,  e_tw[k]);
            check("stage",    k, stage,    e_stg[k]);
         end
         if (rd_en === 1'b1 && n_reads < 64) begin
            obs_a0[n_reads] = int'(rd_addr0);
            obs_a1[n_reads] = int'(rd_addr1);
            obs_tw[n_reads] = int'(tw_addr);
            n_reads++;
         end
         if (bfly_en === 1'b1) n_bf++;
         if (wr_en === 1'b1)   n_wr++;
         if (busy === 1'b1)    n_busy++;
         if (done === 1'b1 && done_cyc < 0) done_cyc = k;
         @(posedge clk); #1;
      end
      start = 1'b0;
      rst   = 1'b0;
`ifdef FFT_SCHED_ABORT_EN
      abort = 1'b0;
`endif
   endtask

   typedef struct {
      int stg; int bfly; int a0; int a1; int tw;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{0, 0, 0,  8, 0};
      vecs[1] = '{0, 1, 1,  9, 1};
      vecs[2] = '{1, 4, 8, 12, 0};
      vecs[3] = '{1, 1, 1,  5, 2};
      vecs[4] = '{3, 1, 2,  3, 0};
      vecs[5] = '{2, 3, 5,  7, 4};
      vecs[6] = '{3, 7, 14, 15, 0};

      rst = 1'b1; start = 1'b0;
`ifdef FFT_SCHED_ABORT_EN
      abort = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 0, busy, 0);
      check("rst_done", 0, done, 0);
      check("rst_rd_en", 0, rd_en, 0);
      check("rst_bfly_en", 0, bfly_en, 0);
      check("rst_wr_en", 0, wr_en, 0);
      check("rst_addrs", 0, {rd_addr0, rd_addr1, wr_addr, tw_addr, stage}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Reset and start together: reset wins, nothing starts.
      start = 1'b1; rst = 1'b1;
      @(negedge clk);
      check("rst_start_busy", 0, busy, 0);
      @(posedge clk); #1;
      start = 1'b0; rst = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check("rst_start_busy", k, busy, 0);
         check("rst_start_rd_en", k, rd_en, 0);
         @(posedge clk); #1;
      end

      // Full run with a stray start mid-run.
      run_sched(20, -1, -1);
      for (int i = 0; i < 7; i++) begin
         int r;
         r = vecs[i].stg * (N / 2) + vecs[i].bfly;
         check("vec_a0", i, obs_a0[r], vecs[i].a0);
         check("vec_a1", i, obs_a1[r], vecs[i].a1);
         check("vec_tw", i, obs_tw[r], vecs[i].tw);
      end
      check("read_count",  0, n_reads,  32);
      check("bfly_count",  0, n_bf,     64);
      check("write_count", 0, n_wr,     64);
      check("busy_cycles", 0, n_busy,   72);
      check("done_cycle",  0, done_cyc, 73);

      // Randomised idle gaps and stray starts.
      for (int r = 0; r < 3; r++) begin
         repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
         run_sched(int'($urandom_range(2, 70)), -1, -1);
         check("rand_done_cycle", r, done_cyc, 73);
      end

      // Reset at cycle 30, then a fresh run keeps nominal timing.
      run_sched(-1, 30, -1);
      check("rst_no_done", 0, done_cyc, -1);
      run_sched(-1, -1, -1);
      check("post_rst_done_cycle", 0, done_cyc, 73);

      // Reset at a random point.
      run_sched(-1, int'($urandom_range(2, 70)), -1);
      check("rand_rst_no_done", 0, done_cyc, -1);
      run_sched(-1, -1, -1);

`ifdef FFT_SCHED_ABORT_EN
      run_sched(-1, -1, 10);
      check("abort_no_done", 0, done_cyc, -1);
      check("abort_busy_cycles", 0, n_busy, 14);
      for (int r = 0; r < 2; r++) begin
         int s;
         s = int'($urandom_range(0, 3));
         run_sched(-1, -1, 1 + s * (N + 2) + int'($urandom_range(0, 15)));
         check("rand_abort_no_done", r, done_cyc, -1);
      end
      run_sched(-1, -1, -1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
